// File: rtl/uart_pixel_loader.sv
// 8N1 UART receiver that writes each good byte as one pixel into the image BRAM.
// It pulses frame_done on the write to the last pixel address, then wraps to address 0.
module uart_pixel_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int PIXELS       = 65536,
    parameter int ADDR_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rxd,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [7:0]        dina,
    output logic              frame_done,
    output logic              frame_err,
    output logic              busy
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0]     BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0]     HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [ADDR_W-1:0] PIX_LAST  = ADDR_W'(PIXELS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t            state_q, state_d;
    logic [1:0]        sync_q, sync_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [2:0]        idx_q, idx_d;
    logic [7:0]        shift_q, shift_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              wea_q, wea_d;
    logic [ADDR_W-1:0] addra_q, addra_d;
    logic [7:0]        dina_q, dina_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              rx_s;

    assign rx_s = sync_q[1];

    always_comb begin
        state_d = state_q;
        sync_d  = {sync_q[0], rxd};
        timer_d = timer_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        wea_d   = 1'b0;
        addra_d = addra_q;
        dina_d  = dina_q;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    timer_d = '0;
                    state_d = START;
                end
            end
            START: begin
                // Re-check the line at mid start bit so short glitches are dropped.
                if (timer_q == HALF_LAST) begin
                    timer_d = '0;
                    if (!rx_s) begin
                        idx_d   = '0;
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DATA: begin
                if (timer_q == BIT_LAST) begin
                    timer_d = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (idx_q == 3'd7) state_d = STOP;
                    else               idx_d   = idx_q + 3'd1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            STOP: begin
                if (timer_q == BIT_LAST) begin
                    timer_d = '0;
                    if (rx_s) begin
                        wea_d   = 1'b1;
                        addra_d = cnt_q;
                        dina_d  = shift_q;
                        done_d  = (cnt_q == PIX_LAST);
                        cnt_d   = (cnt_q == PIX_LAST) ? '0 : cnt_q + 1'b1;
                        state_d = IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            WAIT_IDLE: begin
                // Hold off until the line is released so a break is not decoded as bytes.
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            sync_q  <= 2'b11;
            timer_q <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            cnt_q   <= '0;
            wea_q   <= 1'b0;
            addra_q <= '0;
            dina_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            wea_q   <= wea_d;
            addra_q <= addra_d;
            dina_q  <= dina_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign wea        = wea_q;
    assign addra      = addra_q;
    assign dina       = dina_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_uart_pixel_loader.sv
// Randomised scoreboard bench for uart_pixel_loader: a serial driver plus a pixel-address model
// queue the expected writes, and a monitor pops and compares them on every wea pulse.
`timescale 1ns/1ps
module tb_uart_pixel_loader;
    localparam int CPB    = 50;
    localparam int PIXELS = 27;
    localparam int ADDR_W = 5;
    localparam int BIT_NS = CPB * 10;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [7:0]        d;
        logic              done;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              rxd = 1'b1;
    logic              wea;
    logic [ADDR_W-1:0] addra;
    logic [7:0]        dina;
    logic              frame_done;
    logic              frame_err;
    logic              busy;

    int  checks   = 0;
    int  failures = 0;
    int  exp_cnt  = 0;
    wr_t exp_q[$];

    uart_pixel_loader #(.CLKS_PER_BIT(CPB), .PIXELS(PIXELS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .rxd(rxd), .wea(wea), .addra(addra), .dina(dina),
        .frame_done(frame_done), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: every byte that arrives with a good stop bit lands at the next pixel slot.
    task automatic expect_byte(input logic [7:0] b);
        wr_t w;
        w.a    = ADDR_W'(exp_cnt);
        w.d    = b;
        w.done = (exp_cnt == PIXELS - 1);
        exp_q.push_back(w);
        exp_cnt = (exp_cnt + 1) % PIXELS;
    endtask

    task automatic send_raw(input logic [7:0] b, input int bit_ns, input logic stop_val);
        rxd = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            #(bit_ns);
        end
        rxd = stop_val;
        #(bit_ns);
    endtask

    task automatic send_good(input logic [7:0] b, input int bit_ns);
        expect_byte(b);
        send_raw(b, bit_ns, 1'b1);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b0;
        rxd = 1'b1;
        @(negedge clk);
        chk({tag, "_rst_wea"}, 32'(wea), 0);
        chk({tag, "_rst_addra"}, 32'(addra), 0);
        chk({tag, "_rst_dina"}, 32'(dina), 0);
        chk({tag, "_rst_done"}, 32'(frame_done), 0);
        chk({tag, "_rst_err"}, 32'(frame_err), 0);
        chk({tag, "_rst_busy"}, 32'(busy), 0);
        rst = 1'b1;
        exp_q.delete();
        exp_cnt = 0;
    endtask

    task automatic settle(input string tag);
        #(2 * BIT_NS);
        @(negedge clk);
        chk({tag, "_queue_empty"}, 32'(exp_q.size()), 0);
    endtask

    // Monitor: every write must match the oldest outstanding expectation.
    initial begin
        wr_t e;
        logic prev_wea;
        prev_wea = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && wea) begin
                chk("wea_not_back_to_back", 32'(prev_wea), 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write addra=%0d dina=%02h expected=none", addra, dina);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addra", 32'(addra), 32'(e.a));
                    chk("wr_dina", 32'(dina), 32'(e.d));
                    chk("wr_frame_done", 32'(frame_done), 32'(e.done));
                end
            end else if (rst && frame_done) begin
                checks++;
                failures++;
                $display("FAIL frame_done_without_wea actual=1 expected=0");
            end
            prev_wea = wea;
        end
    end

    initial begin
        logic [7:0] b;
        repeat (3) @(negedge clk);
        do_reset("init");

        // Single byte
        send_good(8'h01, BIT_NS);
        settle("single");
        chk("single_busy", 32'(busy), 0);
        chk("single_err", 32'(frame_err), 0);

        // Contiguous frame with wrap into the next frame
        do_reset("frame");
        for (int i = 1; i <= PIXELS; i++) send_good(8'(i), BIT_NS);
        send_good(8'h55, BIT_NS);
        settle("frame");

        // Framing error followed by a line break
        do_reset("ferr");
        send_raw(8'hA5, BIT_NS, 1'b0);
        #(2 * BIT_NS);
        chk("break_busy", 32'(busy), 1);
        chk("break_err", 32'(frame_err), 1);
        #(BIT_NS);
        rxd = 1'b1;
        #(2 * BIT_NS);
        send_good(8'h3C, BIT_NS);
        settle("ferr");
        chk("ferr_sticky", 32'(frame_err), 1);

        // Glitch shorter than half a bit
        do_reset("glitch");
        @(negedge clk);
        rxd = 1'b0;
        #100;
        chk("glitch_busy_seen", 32'(busy), 1);
        #100;
        rxd = 1'b1;
        #200;
        chk("glitch_busy_low", 32'(busy), 0);
        settle("glitch");

        // Reset during data bit 4 after five good bytes
        do_reset("midrst");
        for (int i = 0; i < 5; i++) send_good(8'($urandom_range(0, 255)), BIT_NS);
        b = 8'h00;
        rxd = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            rxd = b[i];
            #(BIT_NS);
        end
        rxd = b[4];
        #(BIT_NS / 2);
        chk("midrst_busy", 32'(busy), 1);
        do_reset("midrst2");
        #(2 * BIT_NS);
        send_good(8'hC3, BIT_NS);
        settle("midrst");

        // Baud skew at +/-2%
        do_reset("skew");
        send_good(8'h96, BIT_NS * 98 / 100);
        send_good(8'h69, BIT_NS * 102 / 100);
        settle("skew");

        // Random bytes, gaps and baud within tolerance; crosses a frame boundary
        for (int i = 0; i < 30; i++) begin
            send_good(8'($urandom_range(0, 255)), $urandom_range(BIT_NS * 98 / 100, BIT_NS * 102 / 100));
            rxd = 1'b1;
            #($urandom_range(0, BIT_NS + 100));
        end
        settle("random");
        chk("random_err", 32'(frame_err), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
